// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter: host-to-device PS/2 command transmitter.
// Runs inhibit, request-to-send, device-clocked data/parity/stop and
// acknowledge, then reports done or error. Lines are driven open-drain
// through drive-low enables; pad tristates live outside this block.
// Optional build macro: PS2_TX_RETRY_EN (one automatic retry on failure).
// INHIBIT_CYCLES must be at least 2 so the start bit can be set up in the
// last inhibit cycle.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       control_clock,
  input  logic       control_reset_n,
  input  logic [7:0] command_byte,
  input  logic       command_valid,
  output logic       command_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       transmit_busy,
  output logic       transmit_done,
  output logic       transmit_error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] INHIBIT   = 4'd1;
  localparam logic [3:0] START     = 4'd2;
  localparam logic [3:0] DATA      = 4'd3;
  localparam logic [3:0] PARITY    = 4'd4;
  localparam logic [3:0] STOP      = 4'd5;
  localparam logic [3:0] ACK       = 4'd6;
  localparam logic [3:0] WAIT_IDLE = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;
  localparam logic [3:0] ERROR     = 4'd9;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             clk_drv_q, clk_drv_d;
  logic             data_drv_q, data_drv_d;
  logic             timed, fail;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]       byte_q, byte_d;
  logic             retry_q, retry_d;
`endif

  // Resynchronise the raw lines; reset to the idle-high level so no edge is faked
  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // States during which the device owns the clock and the timeout runs
  assign timed = (state_q == START) || (state_q == DATA) || (state_q == PARITY) ||
                 (state_q == STOP)  || (state_q == ACK)  || (state_q == WAIT_IDLE);

  // Frame sequencer: next state, counters and line drives
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d     = byte_q;
    retry_d    = retry_q;
`endif
    case (state_q)
      IDLE: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d    = 1'b0;
`endif
        if (command_valid) begin
          shift_d   = command_byte;
          parity_d  = ~^command_byte;
          cnt_d     = '0;
          bit_cnt_d = '0;
          clk_drv_d = 1'b1;
          state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          byte_d    = command_byte;
`endif
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        // Start bit goes out in the last inhibit cycle so it is already
        // low when the clock line is released.
        if (cnt_q == INH_PRE) data_drv_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          clk_drv_d = 1'b0;
          cnt_d     = '0;
          state_d   = START;
        end
      end
      START: if (fall) begin
        // First device falling edge carries data bit 0
        data_drv_d = ~shift_q[0];
        shift_d    = shift_q >> 1;
        bit_cnt_d  = 3'd1;
        state_d    = DATA;
      end
      DATA: if (fall) begin
        data_drv_d = ~shift_q[0];
        shift_d    = shift_q >> 1;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        data_drv_d = ~parity_q;
        state_d    = STOP;
      end
      STOP: if (fall) begin
        data_drv_d = 1'b0;
        state_d    = ACK;
      end
      ACK: if (fall) begin
        if (data_s) fail = 1'b1;
        else        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_s && data_s) state_d = DONE;
      DONE, ERROR: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

    // Timeout wins over any edge seen in the same cycle
    if (timed) begin
      if (cnt_q == TO_LAST) fail = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end

    if (fail) begin
      clk_drv_d  = 1'b0;
      data_drv_d = 1'b0;
      state_d    = ERROR;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        // Second attempt: same byte and parity, from the inhibit phase
        retry_d   = 1'b1;
        shift_d   = byte_q;
        cnt_d     = '0;
        bit_cnt_d = '0;
        clk_drv_d = 1'b1;
        state_d   = INHIBIT;
      end
`endif
    end
  end

  // Sequencer state registers
  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      byte_q     <= '0;
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
`ifdef PS2_TX_RETRY_EN
      byte_q     <= byte_d;
      retry_q    <= retry_d;
`endif
    end
  end

  assign ps2_clk_drive_low  = clk_drv_q;
  assign ps2_data_drive_low = data_drv_q;
  assign command_ready      = (state_q == IDLE);
  assign transmit_busy      = (state_q != IDLE);
  assign transmit_done      = (state_q == DONE);
  assign transmit_error     = (state_q == ERROR);

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a wired-AND PS/2 device model.
module tb_ps2_host_transmitter;

  localparam int INH  = 40;
  localparam int TO   = 2000;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] command_byte = 8'h00;
  logic       command_valid = 1'b0;
  logic       command_ready;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       transmit_busy, transmit_done, transmit_error;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
  assign data_line = ~(ps2_data_drive_low | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .control_clock(clk), .control_reset_n(rst_n),
    .command_byte(command_byte), .command_valid(command_valid), .command_ready(command_ready),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .transmit_busy(transmit_busy), .transmit_done(transmit_done), .transmit_error(transmit_error)
  );

  int errors = 0;
  int checks = 0;

  // Free-running event counters; tests compare deltas
  int   cyc = 0, clk_lo_cnt = 0, inh_starts = 0, done_cnt = 0, err_cnt = 0;
  int   start_cyc = 0, err_cyc = 0;
  logic prev_cdl = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (ps2_clk_drive_low) clk_lo_cnt++;
    if (ps2_clk_drive_low && !prev_cdl) inh_starts++;
    if (!ps2_clk_drive_low && prev_cdl) start_cyc = cyc;
    if (transmit_done) done_cnt++;
    if (transmit_error) begin err_cnt++; err_cyc = cyc; end
    prev_cdl = ps2_clk_drive_low;
  end

  task automatic wait_ready(input int bound, output bit ok);
    int n = 0;
    while (!command_ready && n < bound) begin @(negedge clk); n++; end
    ok = command_ready;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk); command_byte = b; command_valid = 1'b1;
    @(negedge clk); command_valid = 1'b0;
  endtask

  // Device: wait for request-to-send, clock 11 bits, sample on rising edges
  task automatic device_frame(input bit nack, output logic [10:0] s, output bit ok);
    int n = 0;
    s = '0; ok = 1'b0;
    while (!(clk_line && !data_line) && n < 400) begin @(negedge clk); n++; end
    if (!(clk_line && !data_line)) return;
    ok = 1'b1;
    for (int k = 0; k < 11; k++) begin
      repeat (HALF) @(negedge clk); dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk); dev_clk_low = 1'b0;
      s[k] = data_line;
      if (k == 9) dev_data_low = !nack;
    end
    repeat (HALF) @(negedge clk); dev_data_low = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ps2_clk_drive_low !== 1'b0) begin errors++; $display("FAIL reset_clk_drv got=%b exp=0", ps2_clk_drive_low); end
    checks++; if (ps2_data_drive_low !== 1'b0) begin errors++; $display("FAIL reset_data_drv got=%b exp=0", ps2_data_drive_low); end
    checks++; if (command_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", command_ready); end
    checks++; if (transmit_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", transmit_busy); end
    checks++; if (transmit_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", transmit_done); end
    checks++; if (transmit_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", transmit_error); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_ignore;
    logic any_drv = 1'b0, any_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      repeat (5) @(negedge clk); dev_clk_low = ~dev_clk_low;
      any_drv  = any_drv | ps2_clk_drive_low | ps2_data_drive_low;
      any_busy = any_busy | transmit_busy;
    end
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (any_drv !== 1'b0) begin errors++; $display("FAIL idle_drives got=%b exp=0", any_drv); end
    checks++; if (any_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", any_busy); end
    checks++; if (command_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", command_ready); end
  endtask

  // One good frame; poke drives a competing command while busy
  task automatic test_send(input logic [7:0] b, input bit poke);
    logic [10:0] s;
    bit ok;
    int lo0, d0, e0;
    wait_ready(100, ok);
    lo0 = clk_lo_cnt; d0 = done_cnt; e0 = err_cnt;
    send_cmd(b);
    if (poke) begin
      command_byte = ~b; command_valid = 1'b1;
      repeat (10) @(negedge clk);
      command_valid = 1'b0;
    end
    device_frame(1'b0, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL send_%h_rts got=none exp=request-to-send", b); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (s[i] !== b[i]) begin errors++; $display("FAIL send_%h_bit%0d got=%b exp=%b", b, i, s[i], b[i]); end
    end
    checks++; if (s[8] !== ~^b) begin errors++; $display("FAIL send_%h_parity got=%b exp=%b", b, s[8], ~^b); end
    checks++; if (s[9] !== 1'b1) begin errors++; $display("FAIL send_%h_stop got=%b exp=1", b, s[9]); end
    wait_ready(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL send_%h_ready got=0 exp=1", b); end
    checks++; if (clk_lo_cnt - lo0 != INH) begin errors++; $display("FAIL send_%h_inhibit got=%0d exp=%0d", b, clk_lo_cnt - lo0, INH); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL send_%h_done got=%0d exp=1", b, done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL send_%h_error got=%0d exp=0", b, err_cnt - e0); end
    checks++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin errors++; $display("FAIL send_%h_release got=%b exp=00", b, {ps2_clk_drive_low, ps2_data_drive_low}); end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int n = 0;
    wait_ready(100, ok);
    send_cmd(8'hA5);
    while (!(clk_line && !data_line) && n < 400) begin @(negedge clk); n++; end
    for (int k = 0; k < 4; k++) begin
      repeat (HALF) @(negedge clk); dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk); dev_clk_low = 1'b0;
    end
    repeat (HALF) @(negedge clk); dev_clk_low = 1'b1;
    repeat (6) @(negedge clk);
    // bit4 of 0xA5 is 0, so data must be pulled low here
    checks++; if (ps2_data_drive_low !== 1'b1) begin errors++; $display("FAIL midrst_bit4 got=%b exp=1", ps2_data_drive_low); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ps2_clk_drive_low !== 1'b0) begin errors++; $display("FAIL midrst_clk_drv got=%b exp=0", ps2_clk_drive_low); end
    checks++; if (ps2_data_drive_low !== 1'b0) begin errors++; $display("FAIL midrst_data_drv got=%b exp=0", ps2_data_drive_low); end
    checks++; if (command_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", command_ready); end
    checks++; if (transmit_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", transmit_busy); end
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_send(8'h3C, 1'b0);
  endtask

`ifndef PS2_TX_RETRY_EN
  task automatic test_nack;
    logic [10:0] s;
    bit ok;
    int d0, e0;
    wait_ready(100, ok);
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'hFF);
    device_frame(1'b1, s, ok);
    wait_ready(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_ready got=0 exp=1"); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL nack_error got=%0d exp=1", err_cnt - e0); end
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL nack_done got=%0d exp=0", done_cnt - d0); end
    checks++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin errors++; $display("FAIL nack_release got=%b exp=00", {ps2_clk_drive_low, ps2_data_drive_low}); end
  endtask

  task automatic test_timeout;
    bit ok;
    int d0, e0;
    wait_ready(100, ok);
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'h55);
    wait_ready(INH + TO + 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_ready got=0 exp=1"); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_error got=%0d exp=1", err_cnt - e0); end
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL timeout_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (err_cyc - start_cyc != TO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", err_cyc - start_cyc, TO); end
    checks++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin errors++; $display("FAIL timeout_release got=%b exp=00", {ps2_clk_drive_low, ps2_data_drive_low}); end
  endtask
`else
  task automatic test_retry(input bit second_nack);
    logic [10:0] s;
    bit ok;
    int d0, e0, i0;
    wait_ready(100, ok);
    d0 = done_cnt; e0 = err_cnt; i0 = inh_starts;
    send_cmd(8'hED);
    device_frame(1'b1, s, ok);
    device_frame(second_nack, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retry_rts got=none exp=request-to-send"); end
    checks++; if (s[7:0] !== 8'hED) begin errors++; $display("FAIL retry_byte got=%h exp=ed", s[7:0]); end
    wait_ready(200, ok);
    checks++; if (inh_starts - i0 != 2) begin errors++; $display("FAIL retry_inhibits got=%0d exp=2", inh_starts - i0); end
    checks++; if (done_cnt - d0 != (second_nack ? 0 : 1)) begin errors++; $display("FAIL retry_done got=%0d exp=%0d", done_cnt - d0, second_nack ? 0 : 1); end
    checks++; if (err_cnt - e0 != (second_nack ? 1 : 0)) begin errors++; $display("FAIL retry_error got=%0d exp=%0d", err_cnt - e0, second_nack ? 1 : 0); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignore();
    test_send(8'hED, 1'b0);
    test_send(8'hF4, 1'b1);
    test_send(8'h00, 1'b0);
`ifndef PS2_TX_RETRY_EN
    test_nack();
    test_timeout();
`else
    test_retry(1'b0);
    test_retry(1'b1);
`endif
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
